arbiter_req_conditioner: RTL and testbench



---
 rtl/arbiter_req_conditioner.sv | 173 +++++++++++++++++
 tb/tb_arbiter_req_conditioner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_req_conditioner.sv
// Button front end for the two-player arbiter: synchronise, debounce, press pulse, tie strobe.
// Optional held-too-long detection is built when ARB_REQ_STUCK_DETECT_EN is defined.
module arbiter_req_conditioner #(
    parameter int CLOCK_FREQ     = 12000000,
    parameter int DEBOUNCE_COUNT = CLOCK_FREQ / 1000,
    parameter int STUCK_COUNT    = CLOCK_FREQ * 2
) (
    input  logic       clk,
    input  logic       rst_in_n,
    input  logic       btn1_in_n,
    input  logic       btn2_in_n,
    output logic       req1_out,
    output logic       req2_out,
    output logic       press1_out,
    output logic       press2_out,
    output logic       tie_out,
    output logic       stuck1_out,
    output logic       stuck2_out,
    output logic [3:0] dbg_state_out
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam int CW = $clog2(DEBOUNCE_COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

    if (DEBOUNCE_COUNT < 2 || STUCK_COUNT <= DEBOUNCE_COUNT) begin : g_bad_cfg
        $error("arbiter_req_conditioner: DEBOUNCE_COUNT must be >= 2 and below STUCK_COUNT");
    end

    logic [1:0] w_btn;
    logic [1:0] w_press;
    logic [1:0] w_req;
    logic [1:0] w_stuck;
    logic [3:0] w_dbg;
    logic [1:0] r_press;
    logic       r_tie;

    assign w_btn = {~btn2_in_n, ~btn1_in_n};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [1:0]    r_sync;
        state_t        r_state;
        state_t        w_nxt_state;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_nxt_cnt;
        logic          r_req;
        logic          w_press_cond;
        logic          w_s;

        assign w_s = r_sync[1];

        always_ff @(posedge clk) begin
            if (!rst_in_n) begin
                r_sync  <= 2'b00;
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_req   <= 1'b0;
            end else begin
                r_sync  <= {r_sync[0], w_btn[gi]};
                r_state <= w_nxt_state;
                r_cnt   <= w_nxt_cnt;
                r_req   <= (w_nxt_state == ST_PRESSED) || (w_nxt_state == ST_RELEASE_WAIT);
            end
        end

        always_comb begin
            w_nxt_state  = r_state;
            w_nxt_cnt    = r_cnt;
            w_press_cond = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_s) begin
                        w_nxt_state = ST_PRESS_WAIT;
                        w_nxt_cnt   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_s) begin
                        w_nxt_state = ST_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        w_nxt_state  = ST_PRESSED;
                        w_press_cond = 1'b1;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!w_s) begin
                        w_nxt_state = ST_RELEASE_WAIT;
                        w_nxt_cnt   = '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    // A bounce back to pressed keeps req high and does not re-pulse.
                    if (w_s) begin
                        w_nxt_state = ST_PRESSED;
                    end else if (r_cnt == CNT_LAST) begin
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end

        assign w_press[gi]        = w_press_cond;
        assign w_req[gi]          = r_req;
        assign w_dbg[2*gi +: 2]   = r_state;

`ifdef ARB_REQ_STUCK_DETECT_EN
        localparam int SW = $clog2(STUCK_COUNT + 1);
        localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_COUNT);

        logic [SW-1:0] r_stuck_cnt;
        logic          r_stuck;
        logic          w_held;

        assign w_held = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);

        // Counter restarts only on a fresh acceptance, so release bounces keep the age.
        always_ff @(posedge clk) begin
            if (!rst_in_n) begin
                r_stuck_cnt <= '0;
                r_stuck     <= 1'b0;
            end else begin
                if (w_press_cond) begin
                    r_stuck_cnt <= '0;
                end else if (w_held && r_stuck_cnt != STUCK_MAX) begin
                    r_stuck_cnt <= r_stuck_cnt + 1'b1;
                end
                if (w_nxt_state == ST_IDLE) begin
                    r_stuck <= 1'b0;
                end else if (w_held && r_stuck_cnt == STUCK_MAX) begin
                    r_stuck <= 1'b1;
                end
            end
        end

        assign w_stuck[gi] = r_stuck;
`else
        assign w_stuck[gi] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_in_n) begin
            r_press <= 2'b00;
            r_tie   <= 1'b0;
        end else begin
            r_press <= w_press;
            r_tie   <= w_press[0] & w_press[1];
        end
    end

    assign req1_out      = w_req[0];
    assign req2_out      = w_req[1];
    assign press1_out    = r_press[0];
    assign press2_out    = r_press[1];
    assign tie_out       = r_tie;
    assign stuck1_out    = w_stuck[0];
    assign stuck2_out    = w_stuck[1];
    assign dbg_state_out = w_dbg;

endmodule

// File: tb/tb_arbiter_req_conditioner.sv
// Directed bench for arbiter_req_conditioner: a streak-count reference model predicts
// every output cycle; directed checks pin the edge numbers called out for each scenario.
module tb_arbiter_req_conditioner;

    localparam int D   = 4;
    localparam int STK = 20;

    logic       clk = 1'b0;
    logic       rst_in_n;
    logic       btn1_in_n;
    logic       btn2_in_n;
    logic       req1_out;
    logic       req2_out;
    logic       press1_out;
    logic       press2_out;
    logic       tie_out;
    logic       stuck1_out;
    logic       stuck2_out;
    logic [3:0] dbg_state_out;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    int drv_edge = 0;

    logic [6:0] exp_q[$];

    // Reference model state: synchroniser image, stable-run lengths, request level, held age.
    logic [1:0] m_s1 = 2'b00;
    logic [1:0] m_s2 = 2'b00;
    logic [1:0] m_req = 2'b00;
    int         m_run[2];
    int         m_age[2];

    int   p1_first = 0;
    int   p1_last = 0;
    int   p1_cnt = 0;
    int   p2_last = 0;
    int   tie_cnt = 0;
    int   stuck_hi = 0;
    int   stuck2_rise = 0;
    logic prev_stuck2 = 1'b0;
    int   rel_edge = 0;
    int   p1_before = 0;

    arbiter_req_conditioner #(
        .CLOCK_FREQ    (12000000),
        .DEBOUNCE_COUNT(D),
        .STUCK_COUNT   (STK)
    ) dut (
        .clk          (clk),
        .rst_in_n     (rst_in_n),
        .btn1_in_n    (btn1_in_n),
        .btn2_in_n    (btn2_in_n),
        .req1_out     (req1_out),
        .req2_out     (req2_out),
        .press1_out   (press1_out),
        .press2_out   (press2_out),
        .tie_out      (tie_out),
        .stuck1_out   (stuck1_out),
        .stuck2_out   (stuck2_out),
        .dbg_state_out(dbg_state_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    // Scoreboard: pop the prediction for the edge just passed and compare.
    always @(negedge clk) begin
        logic [6:0] obs;
        logic [6:0] exp_v;
        obs = {stuck2_out, stuck1_out, tie_out, press2_out, press1_out, req2_out, req1_out};
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tests++;
            assert (obs === exp_v) else begin
                fails++;
                $error("FAIL outputs edge %0d observed %b expected %b", edge_n, obs, exp_v);
            end
        end
        if (press1_out === 1'b1) begin
            if (p1_first == 0) p1_first = edge_n;
            p1_last = edge_n;
            p1_cnt++;
        end
        if (press2_out === 1'b1) p2_last = edge_n;
        if (tie_out === 1'b1) tie_cnt++;
        if (stuck1_out === 1'b1 || stuck2_out === 1'b1) stuck_hi++;
        if (stuck2_out === 1'b1 && prev_stuck2 === 1'b0) stuck2_rise = edge_n;
        prev_stuck2 = stuck2_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Outputs after the coming edge: a level is accepted once D+1 consecutive
    // synchronised samples agree; a pulse marks the acceptance of a press.
    task automatic model_edge(input logic b1n, input logic b2n, input logic rstn,
                              output logic [6:0] e);
        logic       s;
        logic [1:0] pr;
        logic [1:0] stk;
        pr  = 2'b00;
        stk = 2'b00;
        if (!rstn) begin
            m_s1  = 2'b00;
            m_s2  = 2'b00;
            m_req = 2'b00;
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0;
                m_age[i] = 0;
            end
            e = '0;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            s = m_s2[i];
            if (!m_req[i]) begin
                m_run[i] = s ? m_run[i] + 1 : 0;
                if (m_run[i] == D + 1) begin
                    m_req[i] = 1'b1;
                    pr[i]    = 1'b1;
                    m_run[i] = 0;
                    m_age[i] = 0;
                end
            end else begin
                m_run[i] = s ? 0 : m_run[i] + 1;
                if (m_run[i] == D + 1) begin
                    m_req[i] = 1'b0;
                    m_run[i] = 0;
                end else begin
                    m_age[i]++;
                end
            end
`ifdef ARB_REQ_STUCK_DETECT_EN
            stk[i] = m_req[i] && (m_age[i] >= STK + 1);
`endif
        end
        m_s2 = m_s1;
        m_s1 = {~b2n, ~b1n};
        e = {stk[1], stk[0], pr[1] & pr[0], pr[1], pr[0], m_req[1], m_req[0]};
    endtask

    task automatic cyc(input logic b1n, input logic b2n, input logic rstn);
        logic [6:0] e;
        btn1_in_n = b1n;
        btn2_in_n = b2n;
        rst_in_n  = rstn;
        drv_edge++;
        model_edge(b1n, b2n, rstn, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic b1n, input logic b2n);
        repeat (n) cyc(b1n, b2n, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
        btn1_in_n = 1'b1;
        btn2_in_n = 1'b1;
        rst_in_n  = 1'b0;

        // Reset for edges 1-3, idle to edge 9, btn1 low from edge 10.
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        check("reset_state", {28'd0, dbg_state_out}, 32'd0);
        check("reset_outputs", {25'd0, stuck2_out, stuck1_out, tie_out, press2_out,
                                press1_out, req2_out, req1_out}, 32'd0);
        run(6, 1'b1, 1'b1);
        run(10, 1'b0, 1'b1);
        check("press1_edge", p1_first, 16);
        run(10, 1'b1, 1'b1);

        // Short press and a rapidly glitching btn2.
        run(3, 1'b0, 1'b1);
        run(8, 1'b1, 1'b1);
        repeat (6) begin
            cyc(1'b1, 1'b0, 1'b1);
            cyc(1'b1, 1'b1, 1'b1);
        end
        run(4, 1'b1, 1'b1);
        check("glitch_no_press1", p1_last, 16);
        check("glitch_no_press2", p2_last, 0);

        // Simultaneous presses tie; offset presses do not.
        run(10, 1'b0, 1'b0);
        run(10, 1'b1, 1'b1);
        check("tie_same_edge", tie_cnt, 1);
        cyc(1'b0, 1'b1, 1'b1);
        run(10, 1'b0, 1'b0);
        run(10, 1'b1, 1'b1);
        check("tie_offset", tie_cnt, 1);

        // Release bounce inside the debounce window.
        p1_before = p1_cnt;
        run(10, 1'b0, 1'b1);
        run(2, 1'b1, 1'b1);
        run(6, 1'b0, 1'b1);
        check("bounce_single_press", p1_cnt, p1_before + 1);
        check("bounce_req_held", {31'd0, req1_out}, 32'd1);
        run(10, 1'b1, 1'b1);

        // Reset during PRESS_WAIT with the button still held afterwards.
        run(4, 1'b0, 1'b1);
        check("in_press_wait", {30'd0, dbg_state_out[1:0]}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        rel_edge = drv_edge + 1;
        run(10, 1'b0, 1'b1);
        check("press_after_reset", p1_last - rel_edge, 6);

        // Reset while btn2 is in PRESSED.
        run(8, 1'b1, 1'b0);
        check("in_pressed", {30'd0, dbg_state_out[3:2]}, 32'd2);
        cyc(1'b1, 1'b0, 1'b0);
        check("reset_from_pressed", {24'd0, req1_out, req2_out, press1_out, press2_out,
                                     tie_out, stuck1_out, stuck2_out, 1'b0}, 32'd0);
        run(8, 1'b1, 1'b1);

        // btn2 held long enough to be flagged as stuck.
        run(30, 1'b1, 1'b0);
        run(10, 1'b1, 1'b1);
`ifdef ARB_REQ_STUCK_DETECT_EN
        check("stuck2_delay", stuck2_rise - p2_last, 21);
`else
        check("stuck_never", stuck_hi, 0);
`endif

        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
